sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one sprite ROM read port among N_REQ sprite drawers. Each drawer issues per-pixel reads: a rd strobe plus a pixel address.
- Arbitrates the requests round-robin and drives the single ROM port.
- Tracks in-flight reads through a ROM_LAT-deep tag pipeline and returns each ROM word to the requester that issued it.
- Sits between the sprite draw units and the shared sprite ROM; also counts arbitration stalls per frame for debug.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 19, ROM address width (covers 640x480 pixels).
- DATA_W, 12, ROM word width (4:4:4 RGB).
- ROM_LAT, 2, ROM read latency in clocks, from the address cycle to the data-valid cycle (1..4).
- STALL_W, 16, stall counter width.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset, sampled on rising clk.
- frame_start  in  1  one-cycle pulse at frame start; clears stall_cnt.
- req  in  N_REQ  per-requester read request; bit i = requester i.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i = [i*ADDR_W +: ADDR_W].
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as req.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd.
- rsp_valid  out  N_REQ  one-cycle pulse; bit i = data for requester i present.
- rsp_data  out  N_REQ*DATA_W  packed per-requester data, sticky (holds last returned word).
- stall_cnt  out  STALL_W  count of cycles in the current frame with at least one ungranted request.

Behaviour:
- Reset (resetN=0 at a clk edge):
  - rr_ptr=0; tag pipeline all invalid.
  - rsp_valid=0, rsp_data=0, stall_cnt=0.
  - gnt=0, rom_rd=0 while resetN=0.
- Arbitration (combinational):
  - Among the asserted req bits, grant the first index at or after rr_ptr, searching upward modulo N_REQ.
  - At most one gnt bit is set; gnt=0 when req=0.
- ROM port:
  - rom_rd = |gnt.
  - rom_addr = address slice of the granted requester; 0 when there is no grant.
- Pointer update (registered):
  - On a cycle with a grant to index g, rr_ptr <= (g+1) mod N_REQ.
  - With no grant, rr_ptr holds.
  - Wrap: a grant to N_REQ-1 sets rr_ptr=0.
- Requester rule: an ungranted requester keeps req high and req_addr stable until granted. The arbiter keeps no queue.
- Tag pipeline:
  - ROM_LAT stages of {valid, id[$clog2(N_REQ)-1:0]}; stage 0 loads {rom_rd, granted index} each cycle.
  - When the last stage is valid with id k, in that same cycle rsp_data slice k <= rom_data and rsp_valid[k] <= 1. Both are registered, so each is visible one cycle later.
  - Total latency: rsp_valid rises ROM_LAT+1 cycles after the grant cycle.
  - rsp_valid bits not selected are 0. Other rsp_data slices are unchanged.
- Throughput: one grant per cycle. Back-to-back grants to the same or different requesters are returned in order, with no bubbles.
- Stall counter:
  - Increments when (req & ~gnt) != 0; saturates at all ones.
  - frame_start takes priority: stall_cnt <= 0 in that cycle, even when a stall is also present.
- Reset mid-operation: in-flight tags are discarded. rom_data arriving after reset produces no rsp_valid.
- ROM_LAT outside 1..4 or N_REQ outside 2..8: elaboration error.

Optional Feature:
- Macro: SPRITE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; lowest asserted index wins. rr_ptr and its update logic are removed. Higher-index requesters may starve; stall_cnt still counts.
- Undefined: round-robin as specified above.

Test Plan:
- Single requester: req=4'b0100, addr2=0x00123, ROM returns 0xABC -> gnt=4'b0100, rom_addr=0x00123 same cycle; rsp_valid[2] pulses once at grant+3 (ROM_LAT=2); rsp_data slice 2=0xABC and stays after req drops.
- All four requesting continuously from reset -> grants cycle 0,1,2,3,0 on consecutive cycles; each rsp_valid bit pulses every 4th cycle, starting at cycles 3,4,5,6; data matches address-derived ROM model.
- req=4'b1001 with rr_ptr=3 -> grant 3, then 0, then 3; wrap-around verified; no grant goes to 1 or 2.
- Stall count: 3 requesters held for 10 cycles -> stall_cnt=10. frame_start in cycle 11 with stall present -> stall_cnt=0 next cycle. With STALL_W=4 and 20 stall cycles -> saturates at 15.
- resetN low for 1 cycle while 2 reads are in flight -> no rsp_valid follows; rsp_data=0; next grant goes to the lowest requesting index (rr_ptr=0).
- With SPRITE_ARB_FIXED_PRIO_EN, req=4'b0011 held 5 cycles -> gnt=4'b0001 every cycle; stall_cnt=5.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port among N_REQ drawers (round-robin, or lowest-index-first with SPRITE_ARB_FIXED_PRIO_EN).
// Response returns ROM_LAT+1 cycles after grant; no queue, so ungranted requesters hold req and address until granted.
module sprite_rom_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 12,
   parameter int ROM_LAT = 2,
   parameter int STALL_W = 16
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    frame_start,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        gnt,
   output logic                    rom_rd,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [N_REQ*DATA_W-1:0] rsp_data,
   output logic [STALL_W-1:0]      stall_cnt
);

   localparam int IDW = $clog2(N_REQ);

   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   generate
      if (ROM_LAT < 1 || ROM_LAT > 4 || N_REQ < 2 || N_REQ > 8) begin : g_param_check
         $error("sprite_rom_arbiter: ROM_LAT must be 1..4 and N_REQ 2..8");
      end
   endgenerate

   logic           gnt_any;
   logic [IDW-1:0] gnt_idx;
   logic [IDW-1:0] cand_idx;
   tag_t           tag_q [ROM_LAT];

`ifndef SPRITE_ARB_FIXED_PRIO_EN
   logic [IDW-1:0] rr_ptr;

   always_ff @(posedge clk) begin
      if (!resetN)
         rr_ptr <= '0;
      else if (gnt_any)
         rr_ptr <= (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
   end
`endif

   // Scan from lowest to highest priority so the last hit written wins.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      cand_idx = '0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      for (int i = N_REQ-1; i >= 0; i--) begin
         cand_idx = IDW'(i);
         if (req[cand_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = cand_idx;
         end
      end
`else
      for (int k = N_REQ-1; k >= 0; k--) begin
         cand_idx = IDW'((int'(rr_ptr) + k) % N_REQ);
         if (req[cand_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = cand_idx;
         end
      end
`endif
      if (!resetN)
         gnt_any = 1'b0;
   end

   always_comb begin
      gnt      = '0;
      rom_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_any && gnt_idx == IDW'(i)) begin
            gnt[i]   = 1'b1;
            rom_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign rom_rd = gnt_any;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int s = 0; s < ROM_LAT; s++)
            tag_q[s] <= '0;
      end else begin
         tag_q[0] <= {gnt_any, gnt_idx};
         for (int s = 1; s < ROM_LAT; s++)
            tag_q[s] <= tag_q[s-1];
      end
   end

   // The last tag stage lines up with the cycle rom_data is valid for that read.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            if (tag_q[ROM_LAT-1].vld && tag_q[ROM_LAT-1].id == IDW'(i)) begin
               rsp_valid[i]                  <= 1'b1;
               rsp_data[i*DATA_W +: DATA_W]  <= rom_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN)
         stall_cnt <= '0;
      else if (frame_start)
         stall_cnt <= '0;
      else if ((|(req & ~gnt)) && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed phases then random traffic, checked by a queue-based scoreboard.
module tb_sprite_rom_arbiter;

   localparam int N_REQ   = 4;
   localparam int ADDR_W  = 19;
   localparam int DATA_W  = 12;
   localparam int ROM_LAT = 2;
   localparam int STALL_W = 4;

   logic                    clk = 1'b0;
   logic                    resetN;
   logic                    frame_start;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0]        gnt;
   logic                    rom_rd;
   logic [ADDR_W-1:0]       rom_addr;
   logic [DATA_W-1:0]       rom_data;
   logic [N_REQ-1:0]        rsp_valid;
   logic [N_REQ*DATA_W-1:0] rsp_data;
   logic [STALL_W-1:0]      stall_cnt;

   always #5 clk = ~clk;

   sprite_rom_arbiter #(
      .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .STALL_W(STALL_W)
   ) dut (
      .clk(clk), .resetN(resetN), .frame_start(frame_start), .req(req), .req_addr(req_addr),
      .gnt(gnt), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .stall_cnt(stall_cnt)
   );

   typedef struct {
      int unsigned       due;
      int                id;
      logic [DATA_W-1:0] dat;
   } rsp_t;

   rsp_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(19'h00123))
         return DATA_W'(12'hABC);
      return a[11:0] ^ {a[18:12], a[4:0]};
   endfunction

   function automatic bit req_bit(input logic [N_REQ-1:0] v, input int i);
      logic [N_REQ-1:0] s;
      s = v >> i;
      return s[0];
   endfunction

   function automatic logic [N_REQ*ADDR_W-1:0] set_addr(input logic [N_REQ*ADDR_W-1:0] v,
                                                         input int i, input logic [ADDR_W-1:0] a);
      logic [N_REQ*ADDR_W-1:0] m;
      m = (N_REQ*ADDR_W)'({ADDR_W{1'b1}}) << (i*ADDR_W);
      return (v & ~m) | ((N_REQ*ADDR_W)'(a) << (i*ADDR_W));
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   // Behavioural ROM: returns rom_fn(address) ROM_LAT cycles after the address cycle.
   logic [ROM_LAT*ADDR_W-1:0] rom_sr = '0;
   always @(posedge clk) rom_sr <= (rom_sr << ADDR_W) | (ROM_LAT*ADDR_W)'(rom_addr);
   assign rom_data = rom_fn(rom_sr[ROM_LAT*ADDR_W-1 -: ADDR_W]);

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: grant choice, ROM port, stall count; pushes expected responses.
   int mptr     = 0;
   int mstall   = 0;
   bit mdl_gany = 1'b0;
   int mdl_gidx = 0;

   always @(negedge clk) begin : model
      int               g;
      int               c;
      logic [N_REQ-1:0]  eg;
      logic [ADDR_W-1:0] ea;
      g  = -1;
      eg = '0;
      ea = '0;
      if (resetN) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
         for (int i = N_REQ-1; i >= 0; i--)
            if (req_bit(req, i)) g = i;
`else
         for (int k = 0; k < N_REQ; k++) begin
            c = (mptr + k) % N_REQ;
            if (g < 0 && req_bit(req, c)) g = c;
         end
`endif
      end
      if (g >= 0) begin
         eg = N_REQ'(1) << g;
         ea = ADDR_W'(req_addr >> (g*ADDR_W));
      end
      chk("gnt", 64'(gnt), 64'(eg));
      chk("rom_rd", 64'(rom_rd), 64'(g >= 0));
      chk("rom_addr", 64'(rom_addr), 64'(ea));
      chk("stall_cnt", 64'(stall_cnt), 64'(mstall));
      if (g >= 0)
         exp_q.push_back('{due: cyc + ROM_LAT + 1, id: g, dat: rom_fn(ea)});
      if (!resetN) begin
         while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
         mptr   = 0;
         mstall = 0;
      end else begin
         if (g >= 0) mptr = (g + 1) % N_REQ;
         if (frame_start) mstall = 0;
         else if ((req & ~eg) != '0 && mstall < (1 << STALL_W) - 1) mstall++;
      end
      mdl_gany = (g >= 0);
      mdl_gidx = g;
   end

   // Monitor: pops the response due this cycle and checks valid pulse and sticky data.
   logic [N_REQ*DATA_W-1:0] mdl_rsp  = '0;
   bit                      zero_nxt = 1'b0;

   always @(negedge clk) begin : monitor
      logic [N_REQ-1:0]        ev;
      logic [N_REQ*DATA_W-1:0] m;
      if (zero_nxt) mdl_rsp = '0;
      zero_nxt = !resetN;
      ev = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         ev      = N_REQ'(1) << exp_q[0].id;
         m       = (N_REQ*DATA_W)'({DATA_W{1'b1}}) << (exp_q[0].id*DATA_W);
         mdl_rsp = (mdl_rsp & ~m) | ((N_REQ*DATA_W)'(exp_q[0].dat) << (exp_q[0].id*DATA_W));
         void'(exp_q.pop_front());
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("rsp_data", 64'(rsp_data), 64'(mdl_rsp));
   end

   // Requester population: pend holds outstanding requests, keep re-requests right after a grant.
   logic [N_REQ-1:0]        pend    = '0;
   logic [N_REQ-1:0]        keep    = '0;
   logic [N_REQ*ADDR_W-1:0] paddr_v = '0;

   task automatic next_cycle();
      @(posedge clk);
      #1;
      if (mdl_gany) begin
         if (req_bit(keep, mdl_gidx)) paddr_v = set_addr(paddr_v, mdl_gidx, ADDR_W'($urandom));
         else pend = pend & ~(N_REQ'(1) << mdl_gidx);
      end
   endtask

   task automatic drive(input logic fs, input logic rn);
      req         = pend;
      req_addr    = paddr_v;
      frame_start = fs;
      resetN      = rn;
   endtask

   task automatic tick(input logic fs, input logic rn, input bit rnd);
      next_cycle();
      if (rnd) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!req_bit(pend, i) && $urandom_range(0, 2) == 0) begin
               pend    = pend | (N_REQ'(1) << i);
               paddr_v = set_addr(paddr_v, i, ADDR_W'($urandom));
            end
         end
      end
      drive(fs, rn);
   endtask

   initial begin
      resetN = 1'b0; frame_start = 1'b0; req = '0; req_addr = '0;
      tick(0, 0, 0);
      tick(0, 0, 0);

      // Single requester 2 at 0x00123
      next_cycle();
      pend = 4'b0100; keep = '0; paddr_v = set_addr(paddr_v, 2, 19'h00123);
      drive(0, 1);
      repeat (7) tick(0, 1, 0);

      // Reset, then all four requesting continuously for 11 cycles (leaves pointer at 3)
      next_cycle(); pend = '0; keep = '0; drive(0, 0);
      next_cycle();
      pend = 4'b1111; keep = 4'b1111;
      for (int i = 0; i < N_REQ; i++) paddr_v = set_addr(paddr_v, i, ADDR_W'($urandom));
      drive(0, 1);
      repeat (10) tick(0, 1, 0);

      // Requesters 0 and 3 only: wrap-around
      next_cycle(); pend = pend & 4'b1001; keep = 4'b1001; drive(0, 1);
      repeat (5) tick(0, 1, 0);

      // Stall counting, frame_start clear, saturation
      next_cycle(); pend = '0; keep = '0; drive(1, 1);
      next_cycle();
      pend = 4'b0111; keep = 4'b0111;
      for (int i = 0; i < 3; i++) paddr_v = set_addr(paddr_v, i, ADDR_W'($urandom));
      drive(0, 1);
      repeat (9) tick(0, 1, 0);
      tick(1, 1, 0);
      repeat (20) tick(0, 1, 0);

      // Two reads in flight when reset hits
      next_cycle(); pend = 4'b1010; keep = 4'b1010; drive(1, 1);
      tick(0, 1, 0);
      tick(0, 0, 0);
      repeat (6) tick(0, 1, 0);

      // Requesters 0 and 1 held together
      next_cycle(); pend = 4'b0011; keep = 4'b0011; drive(1, 1);
      repeat (5) tick(0, 1, 0);

      // Random traffic with occasional frame_start and reset
      next_cycle(); pend = '0; keep = '0; drive(0, 1);
      repeat (3000) tick($urandom_range(0, 99) == 0, $urandom_range(0, 299) != 0, 1);

      // Drain
      next_cycle(); pend = '0; keep = '0; drive(0, 1);
      repeat (8) tick(0, 1, 0);
      @(negedge clk);
      #1;
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
